// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle for the pipelined carry-lookahead adder/subtractor.
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined add/subtract: one carry-lookahead group of BLOCK bits is resolved per
// stage, so a result leaves NBLK cycles after acceptance. The whole pipe freezes
// while the last stage holds a result the consumer has not taken.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_cla_addsub_if.slave bus
);
  localparam int BLK_SAFE = (BLOCK > 0) ? BLOCK : 1;
  localparam int NBLK     = (WIDTH / BLK_SAFE > 0) ? WIDTH / BLK_SAFE : 1;

  if ((BLOCK < 1) || (BLOCK > 8) || ((WIDTH % BLK_SAFE) != 0) || (WIDTH < BLK_SAFE)) begin : g_bad_params
    $error("pipelined_cla_addsub: WIDTH must be a multiple of BLOCK and BLOCK must be 1..8");
  end

  // Per-stage registers. Operands travel with the partial sum; b is stored already
  // inverted for subtraction so later stages do not need the mode bit.
  logic [WIDTH-1:0] st_a   [NBLK];
  logic [WIDTH-1:0] st_b   [NBLK];
  logic [WIDTH-1:0] st_sum [NBLK];
  logic             st_c   [NBLK];
  logic             st_v   [NBLK];
  logic             st_ovf;
  logic             st_zero;

  logic [WIDTH-1:0] nx_a   [NBLK];
  logic [WIDTH-1:0] nx_b   [NBLK];
  logic [WIDTH-1:0] nx_sum [NBLK];
  logic             nx_c   [NBLK];
  logic             nx_v   [NBLK];
  logic             nx_ovf;
  logic             stall;

  assign stall         = st_v[NBLK-1] && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = st_v[NBLK-1];
  assign bus.sum       = st_sum[NBLK-1];
  assign bus.cout      = st_c[NBLK-1];
  assign bus.ovf       = st_ovf;
  assign bus.zero      = st_zero;

  // Next-state of every stage: resolve group k with sum-of-products lookahead carries.
  always_comb begin
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_s;
    logic             src_c;
    logic             src_v;
    logic             term;
    logic [BLOCK-1:0] gp;
    logic [BLOCK-1:0] gg;
    logic [BLOCK:0]   cc;
    src_a  = '0;
    src_b  = '0;
    src_s  = '0;
    src_c  = 1'b0;
    src_v  = 1'b0;
    term   = 1'b0;
    gp     = '0;
    gg     = '0;
    cc     = '0;
    nx_ovf = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      nx_a[k]   = '0;
      nx_b[k]   = '0;
      nx_sum[k] = '0;
      nx_c[k]   = 1'b0;
      nx_v[k]   = 1'b0;
    end
    for (int k = 0; k < NBLK; k++) begin
      if (k == 0) begin
        src_a = bus.a;
        src_b = bus.sub ? ~bus.b : bus.b;
        src_c = bus.sub | bus.cin;
        src_s = '0;
        src_v = bus.in_valid;
      end else begin
        src_a = st_a[(k > 0) ? k - 1 : 0];
        src_b = st_b[(k > 0) ? k - 1 : 0];
        src_c = st_c[(k > 0) ? k - 1 : 0];
        src_s = st_sum[(k > 0) ? k - 1 : 0];
        src_v = st_v[(k > 0) ? k - 1 : 0];
      end
      gp = src_a[k*BLOCK +: BLOCK] ^ src_b[k*BLOCK +: BLOCK];
      gg = src_a[k*BLOCK +: BLOCK] & src_b[k*BLOCK +: BLOCK];
      // c[i] = cin&p[0..i-1] | OR_j ( g[j] & p[j+1..i-1] ), each term flat
      for (int i = 0; i <= BLOCK; i++) begin
        term = src_c;
        for (int j = 0; j < i; j++) term = term & gp[j];
        cc[i] = term;
        for (int j = 0; j < i; j++) begin
          term = gg[j];
          for (int m = j + 1; m < i; m++) term = term & gp[m];
          cc[i] = cc[i] | term;
        end
      end
      nx_a[k]   = src_a;
      nx_b[k]   = src_b;
      nx_sum[k] = src_s;
      nx_sum[k][k*BLOCK +: BLOCK] = gp ^ cc[BLOCK-1:0];
      nx_c[k]   = cc[BLOCK];
      nx_v[k]   = src_v;
      if (k == NBLK - 1) nx_ovf = cc[BLOCK] ^ cc[BLOCK-1];
    end
  end

  // Advance all stages together unless stalled; bubbles move valid=0 but leave data
  // untouched so idle operand inputs never disturb the visible result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NBLK; k++) begin
        st_v[k]   <= 1'b0;
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_sum[k] <= '0;
        st_c[k]   <= 1'b0;
      end
      st_ovf  <= 1'b0;
      st_zero <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < NBLK; k++) begin
        st_v[k] <= nx_v[k];
        if (nx_v[k]) begin
          st_a[k]   <= nx_a[k];
          st_b[k]   <= nx_b[k];
          st_sum[k] <= nx_sum[k];
          st_c[k]   <= nx_c[k];
        end
      end
      if (nx_v[NBLK-1]) begin
        st_ovf  <= nx_ovf;
        st_zero <= (nx_sum[NBLK-1] == '0);
      end
    end
  end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub (WIDTH=16, BLOCK=4): constant vector table, directed
// stall/reset sequences and a long randomized run against an arithmetic reference.
module tb_pipelined_cla_addsub;
  localparam int WIDTH = 16;
  localparam int BLOCK = 4;
  localparam int NBLK  = 4;
  localparam int NV    = 9;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;
  logic mv [NBLK];
  res_t mr [NBLK];
  vec_t vt [NV];

  pipelined_cla_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_cla_addsub #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic res_t ref_calc(input logic [15:0] a_i, input logic [15:0] b_i,
                                    input logic cin_i, input logic sub_i);
    res_t r;
    int ua, ub, sa, sb, ut, st;
    ua = int'(a_i);
    ub = int'(b_i);
    sa = int'($signed(a_i));
    sb = int'($signed(b_i));
    if (sub_i) begin
      ut     = ua - ub;
      st     = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      ut     = ua + ub + int'(cin_i);
      st     = sa + sb + int'(cin_i);
      r.cout = (ut > 65535);
    end
    r.sum  = 16'(ut);
    r.ovf  = (st > 32767) || (st < -32768);
    r.zero = (r.sum == 16'h0000);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic v, input logic [15:0] a_i, input logic [15:0] b_i,
                       input logic cin_i, input logic sub_i, input logic ordy,
                       input logic rst_i);
    logic exp_ov, exp_stall;
    @(negedge clk);
    rst           = rst_i;
    bus.in_valid  = v;
    bus.a         = a_i;
    bus.b         = b_i;
    bus.cin       = cin_i;
    bus.sub       = sub_i;
    bus.out_ready = ordy;
    #1;
    exp_ov    = mv[NBLK-1];
    exp_stall = exp_ov && !ordy;
    chk("out_valid", bus.out_valid, exp_ov);
    chk("in_ready", bus.in_ready, !exp_stall);
    if (exp_ov) begin
      chk("sum", bus.sum, mr[NBLK-1].sum);
      chk("cout", bus.cout, mr[NBLK-1].cout);
      chk("ovf", bus.ovf, mr[NBLK-1].ovf);
      chk("zero", bus.zero, mr[NBLK-1].zero);
    end
    if (rst_i) begin
      for (int k = 0; k < NBLK; k++) mv[k] = 1'b0;
    end else if (!exp_stall) begin
      if (exp_ov && ordy) pops++;
      for (int k = NBLK - 1; k > 0; k--) begin
        mv[k] = mv[k-1];
        mr[k] = mr[k-1];
      end
      mv[0] = v;
      mr[0] = ref_calc(a_i, b_i, cin_i, sub_i);
    end
  endtask

  task automatic bubble(input logic ordy);
    cycle(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy, 1'b0);
  endtask

  task automatic chk_table(input int i);
    chk("tbl_valid", bus.out_valid, 1'b1);
    chk("tbl_sum", bus.sum, vt[i].sum);
    chk("tbl_cout", bus.cout, vt[i].cout);
    chk("tbl_ovf", bus.ovf, vt[i].ovf);
    chk("tbl_zero", bus.zero, vt[i].zero);
  endtask

  initial begin
    int p0;
    vt[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vt[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
    vt[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vt[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 16'hAAAA;
    bus.b         = 16'h5555;
    bus.cin       = 1'b1;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      mv[k] = 1'b0;
      mr[k] = '{16'h0, 1'b0, 1'b0, 1'b0};
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum", bus.sum, 16'h0000);
    chk("rst_cout", bus.cout, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_zero", bus.zero, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // Table vectors, one at a time: result must appear exactly NBLK cycles later.
    for (int i = 0; i < NV; i++) begin
      cycle(1'b1, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, 1'b1, 1'b0);
      repeat (NBLK) bubble(1'b1);
      chk_table(i);
    end

    // Four back-to-back sets, then the consumer stalls for three cycles.
    p0 = pops;
    for (int i = 0; i < 4; i++)
      cycle(1'b1, vt[i+4].a, vt[i+4].b, vt[i+4].cin, vt[i+4].sub, 1'b1, 1'b0);
    bubble(1'b0);
    chk_table(4);
    bubble(1'b0);
    chk_table(4);
    chk("stall_in_ready", bus.in_ready, 1'b0);
    bubble(1'b0);
    chk_table(4);
    repeat (6) bubble(1'b1);
    chk("stall_pop_count", pops - p0, 4);

    // Reset with three sets in flight: they vanish, a fresh set returns on time.
    cycle(1'b1, 16'h0F0F, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 16'hF0F0, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 16'h9999, 16'h9999, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, vt[0].a, vt[0].b, vt[0].cin, vt[0].sub, 1'b1, 1'b0);
    chk("rr_sum", bus.sum, 16'h0000);
    chk("rr_cout", bus.cout, 1'b0);
    chk("rr_ovf", bus.ovf, 1'b0);
    chk("rr_zero", bus.zero, 1'b0);
    chk("rr_in_ready", bus.in_ready, 1'b1);
    repeat (NBLK) bubble(1'b1);
    chk_table(0);

    // Randomized traffic with random valid/ready against the reference model.
    for (int n = 0; n < 10000; n++) begin
      cycle(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
            1'($urandom), ($urandom % 4) != 0, 1'b0);
    end
    repeat (NBLK + 2) bubble(1'b1);
    chk("drain_out_valid", bus.out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter: BLOCK, default 4, carry-lookahead group size in bits; one group is resolved per pipeline stage.
REQ-003 Parameter legality: WIDTH SHALL be a multiple of BLOCK; BLOCK SHALL be in 1..8; violation SHALL be flagged by an elaboration-time error; NBLK = WIDTH/BLOCK.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block can accept an operand set this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in; used in add mode only.
REQ-011 sub  input  1  0 = A+B+cin; 1 = A-B.
REQ-012 out_valid  output  1  result fields valid.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry out of MSB (in sub mode 1 = no borrow).
REQ-016 ovf  output  1  two's-complement signed overflow.
REQ-017 zero  output  1  sum == 0.

Function
REQ-018 Add mode SHALL compute A + B + cin; sub mode SHALL compute A + ~B + 1, ignoring cin.
REQ-019 Each group SHALL use generate/propagate lookahead: P = A^B', G = A&B', carries computed in parallel from group carry-in; no bit-serial ripple within a group.
REQ-020 Stage k (0..NBLK-1) SHALL register group k sum bits, group k carry-out, and the not-yet-processed upper operand bits; lower result bits SHALL be carried forward unchanged.
REQ-021 Handshake: input transfer occurs on a rising edge with in_valid && in_ready; output transfer on a rising edge with out_valid && out_ready.
REQ-022 stall = out_valid && !out_ready; in_ready SHALL equal !stall combinationally.
REQ-023 When stall=1, every pipeline register including valid bits SHALL hold; when stall=0, all stages advance one position.
REQ-024 Latency: a set accepted at edge t SHALL present out_valid=1 with its result after edge t+NBLK-1 (visible in cycle t+NBLK) when no stall occurs; each stall cycle adds exactly one cycle.
REQ-025 Throughput: one result per cycle with out_ready held high; results SHALL leave in acceptance order, none dropped or duplicated.
REQ-026 Bubbles: when in_ready=1 and in_valid=0, a stage with valid=0 SHALL be inserted; bubbles SHALL NOT raise out_valid.
REQ-027 sum, cout, ovf, zero SHALL be registered outputs of the last stage and SHALL remain stable while out_valid && !out_ready.
REQ-028 ovf = carry into MSB XOR carry out of MSB; zero SHALL be 1 exactly when all WIDTH sum bits are 0.
REQ-029 Wrap-around: results are modulo 2^WIDTH; no saturation.
REQ-030 Operand inputs when in_valid=0 SHALL have no effect on any output.

Reset
REQ-031 With rst=1 at a rising edge, all stage valid bits, out_valid, sum, cout, ovf and zero SHALL be 0 after that edge.
REQ-032 rst SHALL override handshake: an input presented in the reset cycle is not accepted, and in-flight sets are discarded and never appear at the output.
REQ-033 in_ready SHALL be 1 in the first cycle after reset is released.

Verification (WIDTH=16, BLOCK=4, NBLK=4)
REQ-034 add a=0x00FF b=0x0001 cin=0, out_ready=1 -> after 4 cycles sum=0x0100 cout=0 ovf=0 zero=0.
REQ-035 add a=0xFFFF b=0x0001 cin=0 -> sum=0x0000 cout=1 ovf=0 zero=1; add a=0x7FFF b=0x0001 -> sum=0x8000 cout=0 ovf=1.
REQ-036 sub a=0x0005 b=0x0007 (cin=1 ignored) -> sum=0xFFFE cout=0 ovf=0; sub a=0x8000 b=0x0001 -> sum=0x7FFF cout=1 ovf=1.
REQ-037 4 back-to-back accepts, out_ready=0 for 3 cycles after first out_valid -> in_ready=0 during stall, outputs stable, all 4 results emitted in order, none lost.
REQ-038 rst=1 for one cycle with 3 sets in flight -> out_valid=0 next cycle, those 3 results never appear, new set afterwards returns after exactly 4 cycles.
REQ-039 Random regression: 10k random a/b/cin/sub with random in_valid/out_ready against a reference model -> zero mismatches, ordering preserved.
